motion_engine: RTL
==================

// Module: motion_engine
// PURPOSE
//   Consumes the per-frame next_frame pulse and Q8.4 step_size from the speed controller.
//   Advances a bouncing object's fixed-point X/Y position once per frame.
//   Reflects the object off the active-area edges.
//   Publishes integer pixel coordinates, direction flags and bounce pulses to the pattern renderer.
// PARAMETERS
//   H_ACTIVE   640  visible width, pixels
//   V_ACTIVE   480  visible height, pixels
//   OBJ_W      32   object width, pixels
//   OBJ_H      32   object height, pixels
//   X_INIT     304  reset/recenter X, pixels (must be <= H_ACTIVE-OBJ_W)
//   Y_INIT     224  reset/recenter Y, pixels (must be <= V_ACTIVE-OBJ_H)
//   DX_INIT    0    reset X direction (0 = +X/right, 1 = -X/left)
//   DY_INIT    0    reset Y direction (0 = +Y/down, 1 = -Y/up)
// PORTS
//   clk         in   1   clock
//   rst         in   1   reset, asynchronous, active-high
//   next_frame  in   1   one-cycle advance pulse
//   step_size   in   12  Q8.4 step, applied to both axes
//   recenter    in   1   synchronous reload of X/Y_INIT and DX/DY_INIT
//   pos_x       out  10  integer X = acc_x[13:4]
//   pos_y       out  10  integer Y = acc_y[13:4]
//   dir_x       out  1   current X direction
//   dir_y       out  1   current Y direction
//   bounce_x    out  1   one-cycle pulse, X reflected this frame
//   bounce_y    out  1   one-cycle pulse, Y reflected this frame
//   corner_hit  out  1   one-cycle pulse, both axes reflected in the same frame
// BEHAVIOUR
// - Reset values:
//   - acc_x = X_INIT<<4; acc_y = Y_INIT<<4.
//   - pos_x/pos_y = X_INIT/Y_INIT.
//   - dir_x/dir_y = DX_INIT/DY_INIT.
//   - All pulses 0.
// - Accumulators: acc_x/acc_y, 14-bit unsigned Q10.4.
//   - XMAX = (H_ACTIVE-OBJ_W)<<4 = 9728; YMAX = (V_ACTIVE-OBJ_H)<<4 = 7168.
//   - Sums are computed 15-bit; there is no wrap.
// - Latency: all outputs are registered and update in the cycle after next_frame is sampled high.
//   Pulses are high for exactly that one cycle.
// - Per axis on next_frame (A = acc, S = step_size, M = axis MAX):
//   - dir=0: N = A+S.
//     - If N >= M: A <= 2M-N (clamped to 0 if negative), dir <= 1, bounce.
//     - Else: A <= N.
//   - dir=1:
//     - If A <= S: A <= S-A (clamped to M if > M), dir <= 0, bounce.
//     - Else: A <= A-S.
//   - Landing exactly on an edge (N == M, A == S) counts as a bounce.
// - corner_hit = bounce_x & bounce_y of the same update.
// - S = 0: position unchanged, no bounce, unless A sits on an edge.
//   - dir=0 with A == M reflects (2M-M = M) and flips.
//   - dir=1 with A == 0 likewise.
// - step_size is sampled only in the next_frame cycle; changes between frames have no effect.
// - recenter has priority over next_frame in the same cycle:
//   - Loads the init values.
//   - Pulses stay 0.
// - rst mid-frame: immediate return to reset values; no pending update survives.
// - Pause is upstream: no next_frame means no motion and no pulses.
// STRUCTURE
// - Shared package (pattern_pkg):
//   - FRAC_BITS = 4, ACC_W = 14.
//   - H_ACTIVE/V_ACTIVE defaults.
//   - Q8.4 step type.
// - Sub-module axis_bouncer (params MAX, INIT, DIR_INIT), instantiated once per axis.
//   - Holds acc, dir and bounce.
//   - motion_engine adds corner_hit, recenter fan-out and the integer slices.
// TESTING
// - Reset, defaults, S=16, one next_frame -> pos_x 305, pos_y 225, dir 0/0, no pulses.
// - X_INIT=606 (acc 9696), S=24, two frames:
//   - Frame 1 -> acc 9720, pos_x 607.
//   - Frame 2 -> acc 9712, pos_x 607, dir_x=1, bounce_x=1 for one cycle.
// - X_INIT=1, DX_INIT=1, S=16, one frame -> acc_x 0, pos_x 0, dir_x=0, bounce_x=1.
// - X_INIT=0, Y_INIT=0, DX=DY=1, S=8 -> pos 0/0, acc 8/8, both dirs 0, bounce_x=bounce_y=corner_hit=1.
// - recenter and next_frame in the same cycle mid-motion -> pos 304/224, dirs DX/DY_INIT, no pulses.
// - rst asserted between frames after 3 updates -> outputs return to reset values immediately; 1000 frames at S=24 keep pos_x <= 608 and pos_y <= 448.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared fixed-point widths, default raster size and the Q8.4 step type for the
// pattern generator blocks.
package pattern_pkg;

    localparam int FRAC_BITS    = 4;
    localparam int ACC_W        = 14;
    localparam int STEP_W       = 12;
    localparam int POS_W        = ACC_W - FRAC_BITS;
    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef logic [STEP_W-1:0] step_q8_4_t;
    typedef logic [ACC_W-1:0]  acc_t;
    typedef logic [POS_W-1:0]  pos_t;

endpackage

// File: rtl/axis_bouncer.sv
// One axis of the bouncing object: Q10.4 position accumulator, direction and
// one-cycle bounce pulse, reflecting off 0 and MAX.
module axis_bouncer
    import pattern_pkg::*;
#(
    parameter int   MAX      = 9728,
    parameter int   INIT     = 4864,
    parameter logic DIR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       reload,
    input  step_q8_4_t step,
    output pos_t       pos,
    output logic       dir,
    output logic       bounce
);

    localparam logic [ACC_W:0]   M_EXT    = (ACC_W+1)'(MAX);
    localparam logic [ACC_W+1:0] TWO_M    = (ACC_W+2)'(2 * MAX);
    localparam acc_t             INIT_ACC = ACC_W'(INIT);

    acc_t           acc;
    acc_t           acc_nxt;
    logic           dir_nxt;
    logic           hit;
    logic [ACC_W:0] sum;
    logic [ACC_W:0] diff;

    // Sums are one bit wider than the accumulator so the edge tests never wrap.
    always_comb begin
        sum     = {1'b0, acc} + {3'b000, step};
        diff    = {3'b000, step} - {1'b0, acc};
        acc_nxt = acc;
        dir_nxt = dir;
        hit     = 1'b0;
        if (!dir) begin
            if (sum >= M_EXT) begin
                hit     = 1'b1;
                dir_nxt = 1'b1;
                if ({1'b0, sum} > TWO_M) acc_nxt = '0;
                else                     acc_nxt = ACC_W'(TWO_M - {1'b0, sum});
            end else begin
                acc_nxt = sum[ACC_W-1:0];
            end
        end else begin
            if ({1'b0, acc} <= {3'b000, step}) begin
                hit     = 1'b1;
                dir_nxt = 1'b0;
                acc_nxt = (diff > M_EXT) ? M_EXT[ACC_W-1:0] : diff[ACC_W-1:0];
            end else begin
                acc_nxt = acc - ACC_W'(step);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= INIT_ACC;
            dir    <= DIR_INIT;
            bounce <= 1'b0;
        end else if (reload) begin
            acc    <= INIT_ACC;
            dir    <= DIR_INIT;
            bounce <= 1'b0;
        end else if (advance) begin
            acc    <= acc_nxt;
            dir    <= dir_nxt;
            bounce <= hit;
        end else begin
            bounce <= 1'b0;
        end
    end

    assign pos = acc[ACC_W-1:FRAC_BITS];

endmodule

// File: rtl/motion_engine.sv
// Bouncing-object motion: two independent axis bouncers advanced once per frame,
// plus the corner pulse and the recenter fan-out.
module motion_engine
    import pattern_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   OBJ_W    = 32,
    parameter int   OBJ_H    = 32,
    parameter int   X_INIT   = 304,
    parameter int   Y_INIT   = 224,
    parameter logic DX_INIT  = 1'b0,
    parameter logic DY_INIT  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       next_frame,
    input  step_q8_4_t step_size,
    input  logic       recenter,
    output pos_t       pos_x,
    output pos_t       pos_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       bounce_x,
    output logic       bounce_y,
    output logic       corner_hit
);

    localparam int XMAX = (H_ACTIVE - OBJ_W) << FRAC_BITS;
    localparam int YMAX = (V_ACTIVE - OBJ_H) << FRAC_BITS;

    // next_frame is a single-cycle strobe with no back-pressure: step_size is
    // taken only in a cycle where next_frame is high, and recenter in the same
    // cycle wins over it.
    axis_bouncer #(
        .MAX     (XMAX),
        .INIT    (X_INIT << FRAC_BITS),
        .DIR_INIT(DX_INIT)
    ) u_axis_x (
        .clk    (clk),
        .rst    (rst),
        .advance(next_frame),
        .reload (recenter),
        .step   (step_size),
        .pos    (pos_x),
        .dir    (dir_x),
        .bounce (bounce_x)
    );

    axis_bouncer #(
        .MAX     (YMAX),
        .INIT    (Y_INIT << FRAC_BITS),
        .DIR_INIT(DY_INIT)
    ) u_axis_y (
        .clk    (clk),
        .rst    (rst),
        .advance(next_frame),
        .reload (recenter),
        .step   (step_size),
        .pos    (pos_y),
        .dir    (dir_y),
        .bounce (bounce_y)
    );

    assign corner_hit = bounce_x & bounce_y;

endmodule
